// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg
// Shared definitions for the MIPS32 instruction fetch stage.
//   MIPS_NOP      : instruction word shown in IF/ID when it holds no instruction
//   MIPS_XLEN     : datapath width
//   MIPS_PC_STEP  : PC increment between sequential instructions
//   fetch_entry_t : one prefetch FIFO entry {instruction, address + 4}
//   ifid_action_t : what the IF/ID register does in a given cycle
//   align_word    : clears the byte-offset bits of an address

package mips_fetch_pkg;

    localparam int          MIPS_XLEN    = 32;
    localparam logic [31:0] MIPS_NOP     = 32'h0000_0000;
    localparam logic [31:0] MIPS_PC_STEP = 32'd4;

    typedef struct packed {
        logic [MIPS_XLEN-1:0] instr;
        logic [MIPS_XLEN-1:0] pc4;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IFID_REDIRECT,
        IFID_HOLD,
        IFID_POP,
        IFID_BUBBLE
    } ifid_action_t;

    function automatic logic [MIPS_XLEN-1:0] align_word(input logic [MIPS_XLEN-1:0] addr);
        return {addr[MIPS_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// mips_fetch_fifo
// Small synchronous prefetch FIFO holding fetched instructions with their PC+4.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   push/wdata : write an entry at the tail
//   pop/rdata  : rdata shows the head; pop removes it
//   clear      : empties the FIFO; wins over a push in the same cycle
//   count      : current number of entries
//   empty/full : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.

module mips_fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    fetch_entry_t  mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage
// IF stage of the 5-stage MIPS32 pipeline. Owns the PC, issues in-order reads
// to instruction memory, buffers returned words in a prefetch FIFO and drives
// the IF/ID register into decode.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr  : instruction read request and word-aligned address
//   imem_rvalid/rdata   : read response, exactly one cycle after the request
//   stall               : hold IF/ID (load-use hazard)
//   redirect/_pc        : taken branch/jump; flush and refetch from redirect_pc
//   if_id_valid/instr   : IF/ID holds a real instruction / the instruction (NOP when invalid)
//   if_id_pc4           : PC of the IF/ID instruction + 4
// Optional build macro MIPS_FETCH_PERF_EN adds perf_stall_cyc and
// perf_bubble_cyc saturating performance counters.

module mips_fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
`ifdef MIPS_FETCH_PERF_EN
    output logic [31:0] if_id_pc4,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_bubble_cyc
`else
    output logic [31:0] if_id_pc4
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   pc_q;
    logic          in_flight_q;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic [CW:0]   occupancy;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    ifid_action_t  action;

    always_comb begin
        action = IFID_BUBBLE;
        if (redirect)         action = IFID_REDIRECT;
        else if (stall)       action = IFID_HOLD;
        else if (!fifo_empty) action = IFID_POP;
    end

    assign fifo_pop = (action == IFID_POP);

    // A head leaving this cycle frees its slot, so the throttle counts it as
    // gone; this keeps one instruction per cycle flowing with a two-deep FIFO.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(in_flight_q) - (CW+1)'(fifo_pop);
    assign imem_req  = rst_n && !redirect && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign imem_addr = pc_q;

    // The response arrives the cycle after its request, when pc_q has already
    // advanced past it, so pc_q is exactly that instruction's PC+4. A response
    // returning during a redirect is discarded by the FIFO clear.
    assign push_entry = '{instr: imem_rdata, pc4: pc_q};
    assign fifo_push  = imem_rvalid && in_flight_q && (!fifo_full || fifo_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            in_flight_q <= 1'b0;
        end else if (redirect) begin
            pc_q        <= align_word(redirect_pc);
            in_flight_q <= 1'b0;
        end else begin
            in_flight_q <= imem_req;
            if (imem_req) pc_q <= pc_q + MIPS_PC_STEP;
        end
    end

    mips_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (redirect),
        .wdata (push_entry),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid <= 1'b0;
            if_id_instr <= MIPS_NOP;
            if_id_pc4   <= '0;
        end else begin
            case (action)
                IFID_POP: begin
                    if_id_valid <= 1'b1;
                    if_id_instr <= head.instr;
                    if_id_pc4   <= head.pc4;
                end
                IFID_HOLD: begin
                    if_id_valid <= if_id_valid;
                    if_id_instr <= if_id_instr;
                    if_id_pc4   <= if_id_pc4;
                end
                default: begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= MIPS_NOP;
                    if_id_pc4   <= if_id_pc4;
                end
            endcase
        end
    end

`ifdef MIPS_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc  <= '0;
            perf_bubble_cyc <= '0;
        end else begin
            if (stall && if_id_valid && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
            if ((action == IFID_REDIRECT || action == IFID_BUBBLE) && (perf_bubble_cyc != '1))
                perf_bubble_cyc <= perf_bubble_cyc + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb_mips_fetch_stage
// Directed self-checking bench for mips_fetch_stage. The memory model returns
// each fetch address as its instruction word, one cycle after the request.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_mips_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_bubble_cyc;
`endif

    int checks;
    int failures;

    mips_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
`ifdef MIPS_FETCH_PERF_EN
        .if_id_pc4       (if_id_pc4),
        .perf_stall_cyc  (perf_stall_cyc),
        .perf_bubble_cyc (perf_bubble_cyc)
`else
        .if_id_pc4       (if_id_pc4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: answers every request one cycle later with its address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
        end else begin
            imem_rvalid <= imem_req;
            imem_rdata  <= imem_addr;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkIfId(input string tag, input logic v, input logic [31:0] instr, input logic [31:0] pc4);
        checkOutput({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
        checkOutput({tag, "_instr"}, if_id_instr, instr);
        checkOutput({tag, "_pc4"}, if_id_pc4, pc4);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Reset values
        @(negedge clk);
        checkOutput("rst_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkIfId("rst", 1'b0, 32'h0, 32'h0);

        // Startup: request at edge 1, FIFO at edge 2, IF/ID valid after edge 3
        rst_n = 1'b1;
        #1;
        checkOutput("t1_req0", {31'b0, imem_req}, 32'h1);
        checkOutput("t1_addr0", imem_addr, 32'h0);
        stepCycle();
        checkOutput("t1_addr1", imem_addr, 32'h4);
        checkOutput("t1_valid1", {31'b0, if_id_valid}, 32'h0);
        stepCycle();
        checkOutput("t1_addr2", imem_addr, 32'h8);
        checkOutput("t1_valid2", {31'b0, if_id_valid}, 32'h0);
        stepCycle();
        checkIfId("t1_c3", 1'b1, 32'h0, 32'h4);
        stepCycle();
        checkIfId("t1_c4", 1'b1, 32'h4, 32'h8);
        stepCycle();
        checkIfId("t1_c5", 1'b1, 32'h8, 32'hC);

        // Stall four cycles: IF/ID frozen, FIFO fills and requests stop
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("t2_req_stalled", {31'b0, imem_req}, 32'h0);
            stepCycle();
            checkIfId("t2_hold", 1'b1, 32'h8, 32'hC);
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t2_req_resume", {31'b0, imem_req}, 32'h1);
        checkOutput("t2_addr_resume", imem_addr, 32'h14);
        stepCycle();
        checkIfId("t2_r1", 1'b1, 32'hC, 32'h10);
        stepCycle();
        checkIfId("t2_r2", 1'b1, 32'h10, 32'h14);
        stepCycle();
        checkIfId("t2_r3", 1'b1, 32'h14, 32'h18);

        // Redirect to 0x40 with a buffered entry and a read returning
        applyStimulus(1'b0, 1'b1, 32'h40);
        checkOutput("t3_req_redirect", {31'b0, imem_req}, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkIfId("t3_flush", 1'b0, 32'h0, 32'h18);
        checkOutput("t3_addr", imem_addr, 32'h40);
        checkOutput("t3_req", {31'b0, imem_req}, 32'h1);
        stepCycle();
        checkOutput("t3_b1_valid", {31'b0, if_id_valid}, 32'h0);
        stepCycle();
        checkOutput("t3_b2_valid", {31'b0, if_id_valid}, 32'h0);
        stepCycle();
        checkIfId("t3_first", 1'b1, 32'h40, 32'h44);
        stepCycle();
        checkIfId("t3_second", 1'b1, 32'h44, 32'h48);

        // Redirect and stall together: redirect wins, low address bits dropped
        applyStimulus(1'b1, 1'b1, 32'h103);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t4_addr", imem_addr, 32'h100);
        checkIfId("t4_flush", 1'b0, 32'h0, 32'h48);
        stepCycle();
        stepCycle();
        stepCycle();
        checkIfId("t4_first", 1'b1, 32'h100, 32'h104);

        // PC wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        stepCycle();
        checkOutput("wrap_addr1", imem_addr, 32'h0);
        stepCycle();
        stepCycle();
        checkIfId("wrap_first", 1'b1, 32'hFFFF_FFFC, 32'h0);
        stepCycle();
        checkIfId("wrap_second", 1'b1, 32'h0, 32'h4);

        // Asynchronous reset between clock edges, then restart from RESET_PC
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_req", {31'b0, imem_req}, 32'h0);
        checkOutput("t5_addr", imem_addr, 32'h0);
        checkIfId("t5_rst", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("t5_restart_addr", imem_addr, 32'h0);
        checkOutput("t5_restart_req", {31'b0, imem_req}, 32'h1);
        stepCycle();
        stepCycle();
        stepCycle();
        checkIfId("t5_first", 1'b1, 32'h0, 32'h4);

`ifdef MIPS_FETCH_PERF_EN
        // Two startup bubbles, then three stalled cycles and one redirect
        checkOutput("t6_bubble_start", perf_bubble_cyc, 32'd2);
        checkOutput("t6_stall_start", perf_stall_cyc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b1, 32'h200);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t6_stall_cyc", perf_stall_cyc, 32'd3);
        checkOutput("t6_bubble_cyc", perf_bubble_cyc, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
